// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter: shares one single-port ROM between the HPS download
// stream and the game read port, and gates game reset around downloads.
module rom_dl_arbiter #(
    parameter int ROM0_SIZE   = 'h2000,
    parameter int ROM1_SIZE   = 'h1000,
    parameter int MEM_AW      = 13,
    parameter int RELEASE_DLY = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              ioctl_wait,
    input  logic              rd_req,
    input  logic              rd_sel,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic              rd_ack,
    output logic [7:0]        rd_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    output logic              game_reset,
    output logic [15:0]       dl_count,
    output logic [7:0]        dl_sum
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD1, S_RD2} state_t;

    localparam logic [24:0] R0_END   = 25'(ROM0_SIZE);
    localparam logic [24:0] R1_END   = 25'(ROM0_SIZE + ROM1_SIZE);
    localparam logic [7:0]  REL_INIT = 8'(RELEASE_DLY);

    state_t            state_q, state_d;
    logic              pending_q, pending_d;
    logic              hold_sel_q, hold_sel_d;
    logic [MEM_AW-1:0] hold_off_q, hold_off_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              rd_ack_q, rd_ack_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_sel_q, mem_sel_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic [15:0]       dl_count_q, dl_count_d;
    logic [7:0]        dl_sum_q, dl_sum_d;
    logic [7:0]        rel_cnt_q, rel_cnt_d;
    logic              dl_prev_q, dl_prev_d;

    logic              in_r0, in_r1, dec_sel, wr_acc, rd_go, dl_rise;
    logic [MEM_AW-1:0] dec_off;

    // A new byte may land while WR drains the previous one, since wait is low there.
    always_comb begin
        in_r0   = ioctl_addr < R0_END;
        in_r1   = !in_r0 && (ioctl_addr < R1_END);
        dec_sel = in_r1;
        dec_off = in_r1 ? MEM_AW'(ioctl_addr - R0_END) : MEM_AW'(ioctl_addr);
        wr_acc  = ioctl_download && ioctl_wr && (in_r0 || in_r1)
                  && (!pending_q || state_q == S_WR);
        rd_go   = rd_req && !rd_ack_q;
        dl_rise = ioctl_download && !dl_prev_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q || wr_acc) state_d = S_WR;
                else if (rd_go)          state_d = S_RD1;
            end
            S_WR: begin
                if (!wr_acc && rd_go) state_d = S_RD1;
                else                  state_d = S_IDLE;
            end
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_sel_d  = mem_sel_q;
        mem_din_d  = mem_din_q;
        rd_ack_d   = (state_q == S_RD2);
        rd_data_d  = (state_q == S_RD2) ? mem_dout : rd_data_q;
        if (state_d == S_WR) begin
            mem_we_d   = 1'b1;
            mem_addr_d = pending_q ? hold_off_q  : dec_off;
            mem_sel_d  = pending_q ? hold_sel_q  : dec_sel;
            mem_din_d  = pending_q ? hold_data_q : ioctl_data;
        end else if (state_d == S_RD1) begin
            mem_addr_d = rd_addr;
            mem_sel_d  = rd_sel;
        end
    end

    always_comb begin
        pending_d   = pending_q;
        hold_sel_d  = hold_sel_q;
        hold_off_d  = hold_off_q;
        hold_data_d = hold_data_q;
        if (state_q == S_WR) pending_d = 1'b0;
        if (wr_acc) begin
            pending_d   = 1'b1;
            hold_sel_d  = dec_sel;
            hold_off_d  = dec_off;
            hold_data_d = ioctl_data;
        end
        dl_count_d = dl_rise ? 16'd0 : dl_count_q;
        dl_sum_d   = dl_rise ? 8'd0  : dl_sum_q;
        if (state_q == S_WR) begin
            dl_count_d = dl_count_d + 16'd1;
            dl_sum_d   = dl_sum_d + mem_din_q;
        end
        if (ioctl_download || pending_q) rel_cnt_d = REL_INIT;
        else if (rel_cnt_q != 8'd0)      rel_cnt_d = rel_cnt_q - 8'd1;
        else                             rel_cnt_d = rel_cnt_q;
        dl_prev_d = ioctl_download;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            hold_sel_q  <= 1'b0;
            hold_off_q  <= '0;
            hold_data_q <= 8'd0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= 8'd0;
            mem_addr_q  <= '0;
            mem_sel_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_din_q   <= 8'd0;
            dl_count_q  <= 16'd0;
            dl_sum_q    <= 8'd0;
            rel_cnt_q   <= REL_INIT;
            dl_prev_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            hold_sel_q  <= hold_sel_d;
            hold_off_q  <= hold_off_d;
            hold_data_q <= hold_data_d;
            rd_ack_q    <= rd_ack_d;
            rd_data_q   <= rd_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_sel_q   <= mem_sel_d;
            mem_we_q    <= mem_we_d;
            mem_din_q   <= mem_din_d;
            dl_count_q  <= dl_count_d;
            dl_sum_q    <= dl_sum_d;
            rel_cnt_q   <= rel_cnt_d;
            dl_prev_q   <= dl_prev_d;
        end
    end

    assign ioctl_wait = (pending_q && state_q != S_WR)
                        || state_q == S_RD1 || state_q == S_RD2;
    assign game_reset = ioctl_download || pending_q || (rel_cnt_q != 8'd0);
    assign rd_ack     = rd_ack_q;
    assign rd_data    = rd_data_q;
    assign mem_addr   = mem_addr_q;
    assign mem_sel    = mem_sel_q;
    assign mem_we     = mem_we_q;
    assign mem_din    = mem_din_q;
    assign dl_count   = dl_count_q;
    assign dl_sum     = dl_sum_q;

endmodule

// File: doc/rom_dl_arbiter.md
Name: rom_dl_arbiter

Overview:
- Shares one single-port ROM/RAM between two requesters: the hps_io ROM download stream (ioctl_*) and the game's read port (CPU program fetch or video graphics fetch).
- Decodes the download address into a program region and a graphics region, and drops bytes outside both.
- Back-pressures the HPS with ioctl_wait while a game read is in flight.
- Holds the game core in reset during download plus a programmable settle time; keeps a byte count and a running checksum for debug/OSD.

Parameters:
- ROM0_SIZE, 'h2000, bytes in region 0 (program ROM), download offset 0.
- ROM1_SIZE, 'h1000, bytes in region 1 (graphics ROM), download offset ROM0_SIZE.
- MEM_AW, 13, memory address width; must satisfy 2**MEM_AW >= max(ROM0_SIZE, ROM1_SIZE).
- RELEASE_DLY, 16, clk_sys cycles game_reset stays high after download ends; legal range 1..255.

Ports:
- clk_sys  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  HPS download active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address of the download stream.
- ioctl_data  in  8  download byte.
- ioctl_wait  out  1  HPS must hold the next ioctl_wr while this is high.
- rd_req  in  1  game read request, level; held until rd_ack.
- rd_sel  in  1  region to read (0 program, 1 graphics).
- rd_addr  in  MEM_AW  read address; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse; rd_data valid in that cycle.
- rd_data  out  8  read data, held until the next ack.
- mem_addr  out  MEM_AW  memory address.
- mem_sel  out  1  memory region select.
- mem_we  out  1  memory write enable.
- mem_din  out  8  memory write data.
- mem_dout  in  8  memory read data, one-cycle registered latency.
- game_reset  out  1  active-high reset to the game core.
- dl_count  out  16  accepted in-range bytes in the current/last download.
- dl_sum  out  8  mod-256 sum of accepted bytes.

Behaviour:
Reset (reset_n=0 at an edge):
- FSM goes to IDLE; write-pending flag cleared.
- ioctl_wait=0, rd_ack=0, rd_data=0, mem_we=0, mem_addr=0, mem_sel=0, mem_din=0.
- dl_count=0, dl_sum=0.
- game_reset=1; release counter loaded with RELEASE_DLY.
- Reset mid-operation abandons any pending write or read; no ack is issued.

Address decode on ioctl_wr (ioctl_download=1):
- addr < ROM0_SIZE -> region 0, offset = addr.
- ROM0_SIZE <= addr < ROM0_SIZE+ROM1_SIZE -> region 1, offset = addr-ROM0_SIZE.
- Otherwise the byte is dropped: no write, no count or sum change.
- An accepted byte latches {sel, offset, data} into the holding register and sets pending.
- ioctl_wr with ioctl_download=0 is ignored.

FSM states: IDLE, WR, RD1, RD2.
- IDLE, pending=1 -> WR. Write has priority over a simultaneous rd_req.
- IDLE, rd_req=1 and no pending -> RD1; drives mem_addr=rd_addr, mem_sel=rd_sel.
- WR (1 cycle): mem_we=1, mem_din/mem_addr/mem_sel from holding register; clears pending; dl_count+=1 (wraps at 16 bits); dl_sum+=data (mod 256); -> IDLE.
- RD1 (1 cycle): memory latency cycle -> RD2.
- RD2: rd_data<=mem_dout; rd_ack=1 for exactly this cycle; -> IDLE.
- Read latency: rd_ack arrives 3 cycles after the first rd_req edge seen in IDLE with no pending write.
- Back-to-back reads are allowed; the earliest re-accept is the cycle after rd_ack.

ioctl_wait:
- High whenever pending=1 and the FSM is not in WR, or whenever the FSM is in RD1/RD2.
- Computed combinationally from registered state.
- A new ioctl_wr while pending=1 is a protocol violation; it is ignored.

Download rising edge:
- dl_count and dl_sum clear to 0.
- game_reset=1.
- An in-flight read still completes.

game_reset:
- 1 while ioctl_download=1 or pending=1.
- Otherwise the release counter decrements once per cycle and game_reset drops on the cycle the counter reaches 0.
- The counter reloads with RELEASE_DLY on any cycle ioctl_download=1 or pending=1.
- After reset_n release with no download, game_reset stays high for RELEASE_DLY cycles.

Test Plan:
- Reset then idle: reset_n low 2 cycles then high -> all outputs 0 except game_reset=1; game_reset drops exactly 16 cycles after reset_n rises.
- Download bytes 0x01,0x02,0x03 at addr 0,1,0x2000 -> mem_we pulses: (sel0, 0, 0x01), (sel0, 1, 0x02), (sel1, 0, 0x03); dl_count=3, dl_sum=0x06.
- Out-of-range: ioctl_wr at addr 0x3000 with data 0xFF -> no mem_we; dl_count and dl_sum unchanged.
- Read: rd_req, sel1, addr 0x005, memory holds 0xA5 -> mem_addr=0x005 in RD1; rd_ack one cycle with rd_data=0xA5 exactly 3 cycles after the request.
- Collision: rd_req and ioctl_wr in the same cycle -> WR issues first, then RD1/RD2; ack is delayed by one cycle. Then a write arriving during RD1 -> ioctl_wait=1 until WR executes.
- End of download: ioctl_download falls while pending=1 -> the write completes first; game_reset falls 16 cycles after pending clears. A new download start resets dl_count to 0.
